entry_buffer: RTL and testbench

//  Output buffer downstream of fetch: accepts one 128-bit TABLE_ENTRY per cycle (fetch ob_valid/entry),

---
 rtl/entry_buffer.sv | 82 ++++++++
 tb/tb_entry_buffer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/entry_buffer.sv
// In-order show-ahead FIFO between fetch and the parse/serialize stage.
// ob_full is an almost-full flag so fetch's in-flight reads always have room.
module entry_buffer #(
  parameter int ENTRY_W   = 128,
  parameter int DEPTH     = 8,
  parameter int AF_MARGIN = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ob_valid,
  input  logic [ENTRY_W-1:0] entry,
  output logic               ob_full,
  input  logic               flush,
  output logic               out_valid,
  output logic [ENTRY_W-1:0] out_entry,
  input  logic               out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic               overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_TH_C = CW'(DEPTH - AF_MARGIN);

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]      r_rd_ptr;
  logic [AW-1:0]      r_wr_ptr;
  logic [CW-1:0]      r_count;
  logic               r_overflow;

  logic w_pop;
  logic w_push;
  logic w_drop;

  assign out_valid = (r_count != '0);
  assign w_pop     = out_valid & out_ready;
  // A full FIFO only accepts a push when the head leaves in the same cycle.
  assign w_push    = ob_valid & ((r_count < DEPTH_C) | w_pop);
  assign w_drop    = ob_valid & ~w_push;

  // Storage is never cleared; only the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (!reset && !flush && w_push) begin
      r_mem[r_wr_ptr] <= entry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign out_entry = r_mem[r_rd_ptr];
  assign count     = r_count;
  assign ob_full   = (r_count >= AF_TH_C);
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_entry_buffer.sv
// Directed and scoreboarded checks for entry_buffer (DEPTH=8, AF_MARGIN=2).
module tb_entry_buffer;

  localparam int W = 128;

  logic         clk = 1'b0;
  logic         reset;
  logic         ob_valid;
  logic [W-1:0] entry;
  logic         ob_full;
  logic         flush;
  logic         out_valid;
  logic [W-1:0] out_entry;
  logic         out_ready;
  logic [3:0]   count;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] q[$];
  logic         exp_ovf;
  logic         m_pop;
  logic         m_push;

  always #5 clk = ~clk;

  entry_buffer #(.ENTRY_W(W), .DEPTH(8), .AF_MARGIN(2)) dut (
    .clk(clk), .reset(reset), .ob_valid(ob_valid), .entry(entry), .ob_full(ob_full),
    .flush(flush), .out_valid(out_valid), .out_entry(out_entry), .out_ready(out_ready),
    .count(count), .overflow(overflow)
  );

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ob_valid = 1'b1; out_ready = 1'b1; flush = 1'b0; entry = 128'hdead;
    // 1: reset with push/pop requests held
    step(); step();
    check_eq("rst_count", W'(count), 0);
    check_eq("rst_out_valid", W'(out_valid), 0);
    check_eq("rst_ob_full", W'(ob_full), 0);
    check_eq("rst_overflow", W'(overflow), 0);
    reset = 1'b0; ob_valid = 1'b0; out_ready = 1'b0;

    // 2: three pushes then drain in order
    for (int i = 1; i <= 3; i++) begin
      ob_valid = 1'b1; entry = W'(i); step();
    end
    ob_valid = 1'b0;
    check_eq("t2_count3", W'(count), 3);
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      check_eq("t2_head", out_entry, W'(i));
      step();
    end
    out_ready = 1'b0;
    check_eq("t2_count0", W'(count), 0);
    check_eq("t2_out_valid0", W'(out_valid), 0);

    // 3: almost-full threshold, full, overflow drop
    for (int i = 0; i < 8; i++) begin
      ob_valid = 1'b1; entry = W'(16 + i); step();
      if (i == 4) check_eq("t3_not_full_at5", W'(ob_full), 0);
      if (i == 5) check_eq("t3_full_at6", W'(ob_full), 1);
    end
    check_eq("t3_count8", W'(count), 8);
    check_eq("t3_ovf_before", W'(overflow), 0);
    entry = 128'h99; step();
    ob_valid = 1'b0;
    check_eq("t3_ovf_set", W'(overflow), 1);
    check_eq("t3_count_still8", W'(count), 8);
    check_eq("t3_head_unchanged", out_entry, W'(16));
    flush = 1'b1; step(); flush = 1'b0;
    check_eq("t3_ovf_survives_flush", W'(overflow), 1);

    // 4: full with simultaneous push/pop, then wrap-around pairs
    do_reset();
    check_eq("t4_ovf_cleared", W'(overflow), 0);
    q.delete();
    for (int i = 0; i < 8; i++) begin
      ob_valid = 1'b1; entry = W'(32 + i); q.push_back(entry); step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      entry = {$urandom, $urandom, $urandom, $urandom};
      check_eq("t4_head", out_entry, q[0]);
      step();
      void'(q.pop_front());
      q.push_back(entry);
      check_eq("t4_count8", W'(count), 8);
    end
    check_eq("t4_ovf_still0", W'(overflow), 0);
    ob_valid = 1'b0;
    while (q.size() != 0) begin
      check_eq("t4_drain", out_entry, q[0]);
      void'(q.pop_front());
      step();
    end
    out_ready = 1'b0;
    check_eq("t4_empty", W'(out_valid), 0);

    // 5: flush beats same-cycle push and pop
    for (int i = 0; i < 5; i++) begin
      ob_valid = 1'b1; entry = W'(64 + i); step();
    end
    check_eq("t5_count5", W'(count), 5);
    flush = 1'b1; ob_valid = 1'b1; out_ready = 1'b1; entry = 128'h77; step();
    flush = 1'b0; ob_valid = 1'b0; out_ready = 1'b0;
    check_eq("t5_count0", W'(count), 0);
    check_eq("t5_out_valid0", W'(out_valid), 0);
    check_eq("t5_ob_full0", W'(ob_full), 0);
    step();
    check_eq("t5_push_absent", W'(count), 0);

    // 6: no bypass on empty FIFO
    ob_valid = 1'b1; out_ready = 1'b1; entry = 128'h55; step();
    ob_valid = 1'b0;
    check_eq("t6_valid_after_N", W'(out_valid), 1);
    check_eq("t6_count1_no_pop", W'(count), 1);
    check_eq("t6_head", out_entry, 128'h55);
    step();
    check_eq("t6_popped_N1", W'(count), 0);
    out_ready = 1'b0;

    // 6b: random soak against a queue model
    do_reset();
    q.delete();
    exp_ovf = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      ob_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 50);
      entry     = {$urandom, $urandom, $urandom, $urandom};
      m_pop  = (q.size() != 0) && out_ready;
      m_push = ob_valid && ((q.size() < 8) || m_pop);
      if (ob_valid && !m_push) exp_ovf = 1'b1;
      step();
      if (m_pop) void'(q.pop_front());
      if (m_push) q.push_back(entry);
      check_eq("soak_count", W'(count), W'(q.size()));
      if (q.size() != 0) check_eq("soak_head", out_entry, q[0]);
      else check_eq("soak_empty", W'(out_valid), 0);
    end
    check_eq("soak_overflow", W'(overflow), W'(exp_ovf));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
